// File: rtl/prog_truth_table.sv
// prog_truth_table: programmable truth-table evaluator with a one-entry,
// valid/ready flow-controlled output register.
//
// A 2^IN_W x OUT_W lookup table is loaded from INIT at reset and can be
// rewritten at run time through the cfg_* port. Each accepted input word is
// either looked up in the table (mode=0) or reduced to an arithmetic majority
// vote (mode=1). The result appears one cycle after accept and is held until
// the sink takes it.
//
// Optional feature macro: PROG_TT_COUNT_EN
//   When defined, a 16-bit saturating accepted-word counter is exposed on
//   txn_cnt. When undefined, neither the port nor the counter exists.

module prog_truth_table #(
  parameter int                          IN_W  = 3,
  parameter int                          OUT_W = 1,
  parameter logic [OUT_W*(2**IN_W)-1:0]  INIT  = 8'hE8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cfg_we,
  input  logic [IN_W-1:0]  cfg_addr,
  input  logic [OUT_W-1:0] cfg_data,
  input  logic             mode,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  input  logic             out_ready
`ifdef PROG_TT_COUNT_EN
  ,
  output logic [15:0]      txn_cnt
`endif
);

  localparam int DEPTH = 2**IN_W;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  // Number of set bits in an input vector.
  function automatic int f_popcount(input logic [IN_W-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < IN_W; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

  // Strict majority vote replicated across the output word; a tie on an
  // even-width input votes 0 because of the integer halving.
  function automatic logic [OUT_W-1:0] f_majority(input logic [IN_W-1:0] v);
    return (f_popcount(v) > (IN_W / 2)) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
  endfunction

`ifdef PROG_TT_COUNT_EN
  // Saturating increment: the counter sticks at all-ones.
  function automatic logic [15:0] f_sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction
`endif

  logic [OUT_W-1:0] r_table [DEPTH];
  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_in_ready;
  logic             w_accept_p0;
  logic [OUT_W-1:0] w_result_p0;
  logic [OUT_W-1:0] r_data_p1;
  logic             w_vld_p1;

  // ---- stage p0: input accept and result selection ----

  // Table read uses the registered contents, so a same-cycle write to the
  // same address is not yet visible to this lookup.
  always_comb begin
    w_result_p0 = r_table[in_data];
    if (mode) begin
      w_result_p0 = f_majority(in_data);
    end
  end

  assign w_accept_p0 = in_valid && w_in_ready;

  // Table storage: INIT image on reset, single write port otherwise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_table[k] <= INIT[k*OUT_W +: OUT_W];
      end
    end else if (cfg_we) begin
      r_table[cfg_addr] <= cfg_data;
    end
  end

  // Output occupancy state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and ready: an empty slot always accepts; a full slot accepts
  // only when its current word is leaving this cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    case (r_state)
      S_EMPTY: begin
        w_in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_FULL;
      end
      S_FULL: begin
        w_in_ready = out_ready;
        if (out_ready && !in_valid) w_state_nxt = S_EMPTY;
      end
      default: begin
        w_state_nxt = S_EMPTY;
      end
    endcase
  end

  // ---- stage p1: held output word ----

  // Result register loads only on accept, so it stays frozen under
  // backpressure regardless of later mode or table changes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_data_p1 <= '0;
    end else if (w_accept_p0) begin
      r_data_p1 <= w_result_p0;
    end
  end

  assign w_vld_p1  = (r_state == S_FULL);
  assign in_ready  = w_in_ready;
  assign out_valid = w_vld_p1;
  assign out_data  = r_data_p1;

`ifdef PROG_TT_COUNT_EN
  logic [15:0] r_txn_cnt;

  // Accepted-word counter, saturating at all-ones.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_txn_cnt <= 16'd0;
    end else if (w_accept_p0) begin
      r_txn_cnt <= f_sat_inc(r_txn_cnt);
    end
  end

  assign txn_cnt = r_txn_cnt;
`endif

endmodule
